// File: rtl/multi_perf_counter_if.sv
// rtl/multi_perf_counter_if.sv - pc watch, channel config, readout and status bundle
interface multi_perf_counter_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0]        pc;
  logic                     pc_valid;
  logic [NUM_CH*ADDR_W-1:0] start_pc;
  logic [NUM_CH*ADDR_W-1:0] stop_pc;
  logic [NUM_CH-1:0]        accumulate;
  logic                     clear;
  logic [2:0]               rd_ch;
  logic                     rd_hund;
  logic [2:0]               rd_window;
  logic [11:0]              rd_data;
  logic [NUM_CH-1:0]        ch_running;
  logic [NUM_CH-1:0]        ch_done;
  logic [NUM_CH-1:0]        ch_sat;
  logic                     all_done;

  modport master (
    output pc, pc_valid, start_pc, stop_pc, accumulate, clear, rd_ch, rd_hund, rd_window,
    input  rd_data, ch_running, ch_done, ch_sat, all_done
  );

  modport slave (
    input  pc, pc_valid, start_pc, stop_pc, accumulate, clear, rd_ch, rd_hund, rd_window,
    output rd_data, ch_running, ch_done, ch_sat, all_done
  );
endinterface

// File: rtl/multi_perf_counter.sv
// rtl/multi_perf_counter.sv - multi-channel PC-window cycle/hundredths counter
// Each channel counts cycles between start/stop pc matches; a 2-stage readout formats hex or decimal.
module multi_perf_counter #(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 16,
  parameter int CNT_W    = 32,
  parameter int HUND_W   = 14,
  parameter int PRESCALE = 500_000
) (
  input logic                 CLK_50,
  input logic                 reset,
  multi_perf_counter_if.slave bus
);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int OUT_DIGITS = 24;
  localparam logic [CNT_W-1:0]  CYC_MAX  = '1;
  localparam logic [HUND_W-1:0] HUND_MAX = '1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);

  function automatic int dec_digits(input int w);
    longint v;
    int n;
    v = (longint'(1) << w) - 1;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n = n + 1;
    end
    return n;
  endfunction

  function automatic logic [31:0] pow10(input int k);
    logic [31:0] p;
    p = 32'd1;
    for (int j = 0; j < k; j++) p = p * 32'd10;
    return p;
  endfunction

  localparam int DEC_DIGITS = dec_digits(HUND_W);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [CNT_W-1:0]  cyc_q   [NUM_CH];
  logic [CNT_W-1:0]  cyc_d   [NUM_CH];
  logic [PRE_W-1:0]  presc_q [NUM_CH];
  logic [PRE_W-1:0]  presc_d [NUM_CH];
  logic [HUND_W-1:0] hund_q  [NUM_CH];
  logic [HUND_W-1:0] hund_d  [NUM_CH];
  logic [NUM_CH-1:0] sat_q, sat_d;
  logic [NUM_CH-1:0] running_q, running_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic              all_done_q, all_done_d;
  logic [NUM_CH-1:0] start_hit, stop_hit;

  logic [CNT_W-1:0]  sel_cyc_q, sel_cyc_d;
  logic [HUND_W-1:0] sel_hund_q, sel_hund_d;
  logic              sel_dec_q, sel_dec_d;
  logic [2:0]        sel_win_q, sel_win_d;
  logic [11:0]       rd_data_q, rd_data_d;
  logic [4*OUT_DIGITS-1:0] hex_ext, dec_ext;
  logic [31:0]       hund_ext;

  always_comb begin
    start_hit = '0;
    stop_hit  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      start_hit[i] = bus.pc_valid && (bus.pc == bus.start_pc[i*ADDR_W +: ADDR_W]);
      stop_hit[i]  = bus.pc_valid && (bus.pc == bus.stop_pc[i*ADDR_W +: ADDR_W]);
    end
  end

  // Start wins outside RUN, stop wins inside RUN; clear overrides both.
  always_comb begin
    sat_d     = '0;
    running_d = '0;
    done_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cyc_d[i]   = cyc_q[i];
      presc_d[i] = presc_q[i];
      hund_d[i]  = hund_q[i];
      if (bus.clear) begin
        state_d[i] = ST_IDLE;
        cyc_d[i]   = '0;
        presc_d[i] = '0;
        hund_d[i]  = '0;
      end else begin
        unique case (state_q[i])
          ST_IDLE: if (start_hit[i]) state_d[i] = ST_RUN;
          ST_RUN: begin
            if (cyc_q[i] != CYC_MAX) cyc_d[i] = cyc_q[i] + 1'b1;
            if (hund_q[i] != HUND_MAX) begin
              if (presc_q[i] == PRE_LAST) begin
                presc_d[i] = '0;
                hund_d[i]  = hund_q[i] + 1'b1;
              end else begin
                presc_d[i] = presc_q[i] + 1'b1;
              end
            end
            if (stop_hit[i]) state_d[i] = ST_DONE;
          end
          ST_DONE: if (start_hit[i] && bus.accumulate[i]) state_d[i] = ST_RUN;
          default: state_d[i] = ST_IDLE;
        endcase
      end
      sat_d[i]     = !bus.clear && (sat_q[i] || (cyc_d[i] == CYC_MAX) || (hund_d[i] == HUND_MAX));
      running_d[i] = (state_d[i] == ST_RUN);
      done_d[i]    = (state_d[i] == ST_DONE);
    end
    all_done_d = &done_d;
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cyc_q[i]   <= '0;
        presc_q[i] <= '0;
        hund_q[i]  <= '0;
      end
      sat_q      <= '0;
      running_q  <= '0;
      done_q     <= '0;
      all_done_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cyc_q[i]   <= cyc_d[i];
        presc_q[i] <= presc_d[i];
        hund_q[i]  <= hund_d[i];
      end
      sat_q      <= sat_d;
      running_q  <= running_d;
      done_q     <= done_d;
      all_done_q <= all_done_d;
    end
  end

  // Out-of-range channels select zero, which formats to zero in either mode.
  always_comb begin
    sel_cyc_d  = '0;
    sel_hund_d = '0;
    sel_dec_d  = bus.rd_hund;
    sel_win_d  = bus.rd_window;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.rd_ch == 3'(i)) begin
        sel_cyc_d  = cyc_q[i];
        sel_hund_d = hund_q[i];
      end
    end
  end

  always_comb begin
    hex_ext = '0;
    dec_ext = '0;
    hex_ext[CNT_W-1:0] = sel_cyc_q;
    hund_ext = 32'(sel_hund_q);
    for (int k = 0; k < DEC_DIGITS; k++) begin
      dec_ext[4*k +: 4] = 4'((hund_ext / pow10(k)) % 32'd10);
    end
    rd_data_d = sel_dec_q ? dec_ext[12*sel_win_q +: 12] : hex_ext[12*sel_win_q +: 12];
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      sel_cyc_q  <= '0;
      sel_hund_q <= '0;
      sel_dec_q  <= 1'b0;
      sel_win_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      sel_cyc_q  <= sel_cyc_d;
      sel_hund_q <= sel_hund_d;
      sel_dec_q  <= sel_dec_d;
      sel_win_q  <= sel_win_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.ch_running = running_q;
  assign bus.ch_done    = done_q;
  assign bus.ch_sat     = sat_q;
  assign bus.all_done   = all_done_q;
endmodule

// File: tb/tb_multi_perf_counter.sv
// tb/tb_multi_perf_counter.sv - self-checking bench for multi_perf_counter
module tb_multi_perf_counter;
  localparam int NUM_CH = 4, ADDR_W = 16, PRESCALE = 10;
  localparam int CNT_W_A = 32, HUND_W_A = 14, CNT_W_B = 8, HUND_W_B = 4;
  localparam longint CMAX_A = (longint'(1) << CNT_W_A) - 1;
  localparam longint HMAX_A = (longint'(1) << HUND_W_A) - 1;
  localparam longint CMAX_B = (longint'(1) << CNT_W_B) - 1;
  localparam longint HMAX_B = (longint'(1) << HUND_W_B) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset;
  logic [ADDR_W-1:0]        pc;
  logic                     pc_valid;
  logic [NUM_CH*ADDR_W-1:0] start_pc, stop_pc;
  logic [NUM_CH-1:0]        accumulate;
  logic                     clear;
  logic [2:0]               rd_ch;
  logic                     rd_hund;
  logic [2:0]               rd_window;

  multi_perf_counter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus_a ();
  multi_perf_counter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus_b ();

  assign bus_a.pc = pc;                 assign bus_b.pc = pc;
  assign bus_a.pc_valid = pc_valid;     assign bus_b.pc_valid = pc_valid;
  assign bus_a.start_pc = start_pc;     assign bus_b.start_pc = start_pc;
  assign bus_a.stop_pc = stop_pc;       assign bus_b.stop_pc = stop_pc;
  assign bus_a.accumulate = accumulate; assign bus_b.accumulate = accumulate;
  assign bus_a.clear = clear;           assign bus_b.clear = clear;
  assign bus_a.rd_ch = rd_ch;           assign bus_b.rd_ch = rd_ch;
  assign bus_a.rd_hund = rd_hund;       assign bus_b.rd_hund = rd_hund;
  assign bus_a.rd_window = rd_window;   assign bus_b.rd_window = rd_window;

  multi_perf_counter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W_A), .HUND_W(HUND_W_A),
                       .PRESCALE(PRESCALE)) dut_a (.CLK_50(clk), .reset(reset), .bus(bus_a));
  multi_perf_counter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W_B), .HUND_W(HUND_W_B),
                       .PRESCALE(PRESCALE)) dut_b (.CLK_50(clk), .reset(reset), .bus(bus_b));

  int n_checks = 0;
  int n_pass = 0;

  // Reference: per-channel state (0 idle, 1 run, 2 done) and total RUN cycles seen.
  int          m_state [NUM_CH];
  longint      m_run   [NUM_CH];
  logic [11:0] m_p1    [2];
  logic [11:0] m_p2    [2];

  function automatic longint cyc_of(int x, int ch);
    longint m = (x == 0) ? CMAX_A : CMAX_B;
    return (m_run[ch] < m) ? m_run[ch] : m;
  endfunction

  function automatic longint hund_of(int x, int ch);
    longint m = (x == 0) ? HMAX_A : HMAX_B;
    longint h = m_run[ch] / PRESCALE;
    return (h < m) ? h : m;
  endfunction

  function automatic logic [11:0] fmt(int x);
    logic [11:0] r;
    longint unsigned v;
    longint unsigned p;
    int w;
    r = '0;
    w = int'(rd_window);
    if (int'(rd_ch) >= NUM_CH) return 12'h000;
    if (!rd_hund) begin
      v = longint'(cyc_of(x, int'(rd_ch)));
      if (12 * w < 64) r = 12'(v >> (12 * w));
    end else begin
      if (3 * w > 18) return 12'h000;
      v = longint'(hund_of(x, int'(rd_ch)));
      p = 1;
      for (int j = 0; j < 3 * w; j++) p = p * 10;
      v = v / p;
      for (int d = 0; d < 3; d++) begin
        r[4*d +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  task automatic model_edge();
    logic st, sp;
    for (int x = 0; x < 2; x++) begin
      if (reset) begin
        m_p1[x] = '0;
        m_p2[x] = '0;
      end else begin
        m_p2[x] = m_p1[x];
        m_p1[x] = fmt(x);
      end
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      st = pc_valid && (pc == start_pc[ch*ADDR_W +: ADDR_W]);
      sp = pc_valid && (pc == stop_pc[ch*ADDR_W +: ADDR_W]);
      if (reset || clear) begin
        m_state[ch] = 0;
        m_run[ch] = 0;
      end else begin
        case (m_state[ch])
          0: if (st) m_state[ch] = 1;
          1: begin
            m_run[ch] = m_run[ch] + 1;
            if (sp) m_state[ch] = 2;
          end
          default: if (st && accumulate[ch]) m_state[ch] = 1;
        endcase
      end
    end
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic check_inst(string tag, int x, logic [11:0] rd, logic [NUM_CH-1:0] run,
                            logic [NUM_CH-1:0] done, logic [NUM_CH-1:0] sat, logic ad);
    logic [NUM_CH-1:0] e_run, e_done, e_sat;
    longint cm, hm;
    cm = (x == 0) ? CMAX_A : CMAX_B;
    hm = (x == 0) ? HMAX_A : HMAX_B;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      e_run[ch]  = (m_state[ch] == 1);
      e_done[ch] = (m_state[ch] == 2);
      e_sat[ch]  = (cyc_of(x, ch) == cm) || (hund_of(x, ch) == hm);
    end
    check({tag, "_rd_data"}, 32'(rd), 32'(m_p2[x]));
    check({tag, "_ch_running"}, 32'(run), 32'(e_run));
    check({tag, "_ch_done"}, 32'(done), 32'(e_done));
    check({tag, "_ch_sat"}, 32'(sat), 32'(e_sat));
    check({tag, "_all_done"}, 32'(ad), 32'(&e_done));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_inst("a", 0, bus_a.rd_data, bus_a.ch_running, bus_a.ch_done, bus_a.ch_sat, bus_a.all_done);
    check_inst("b", 1, bus_b.rd_data, bus_b.ch_running, bus_b.ch_done, bus_b.ch_sat, bus_b.all_done);
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic emit(logic [ADDR_W-1:0] a);
    pc = a;
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    pc = '0;
  endtask

  task automatic readout(logic [2:0] ch, logic dec, logic [2:0] win);
    rd_ch = ch;
    rd_hund = dec;
    rd_window = win;
    idle(2);
  endtask

  typedef struct {
    logic [2:0]  ch;
    logic        dec;
    logic [2:0]  win;
    logic [11:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [13];
  logic [ADDR_W-1:0] pool [5];

  initial begin
    vecs[0]  = '{3'd0, 1'b0, 3'd0, 12'h064};
    vecs[1]  = '{3'd0, 1'b1, 3'd0, 12'h010};
    vecs[2]  = '{3'd1, 1'b0, 3'd0, 12'h039};
    vecs[3]  = '{3'd1, 1'b0, 3'd1, 12'h003};
    vecs[4]  = '{3'd1, 1'b0, 3'd2, 12'h000};
    vecs[5]  = '{3'd1, 1'b1, 3'd0, 12'h234};
    vecs[6]  = '{3'd1, 1'b1, 3'd1, 12'h001};
    vecs[7]  = '{3'd2, 1'b0, 3'd0, 12'h050};
    vecs[8]  = '{3'd2, 1'b1, 3'd0, 12'h008};
    vecs[9]  = '{3'd3, 1'b0, 3'd0, 12'h032};
    vecs[10] = '{3'd3, 1'b1, 3'd0, 12'h005};
    vecs[11] = '{3'd7, 1'b0, 3'd0, 12'h000};
    vecs[12] = '{3'd4, 1'b1, 3'd0, 12'h000};
    pool = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050};

    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_state[ch] = 0;
      m_run[ch] = 0;
    end
    m_p1[0] = '0; m_p1[1] = '0; m_p2[0] = '0; m_p2[1] = '0;
    reset = 1'b1; pc = '0; pc_valid = 1'b0; clear = 1'b0;
    rd_ch = '0; rd_hund = 1'b0; rd_window = '0;
    start_pc = {16'h0050, 16'h0050, 16'h0030, 16'h0010};
    stop_pc  = {16'h0060, 16'h0060, 16'h0031, 16'h0020};
    accumulate = 4'b0100;
    idle(3);
    check("reset_rd_data", 32'(bus_a.rd_data), 32'h0);
    check("reset_status", 32'({bus_a.ch_running, bus_a.ch_done, bus_a.ch_sat, bus_a.all_done}), 32'h0);
    reset = 1'b0;
    idle(2);
    check("post_reset_rd_data", 32'(bus_a.rd_data), 32'h0);

    emit(16'h0010);
    check("t1_running", 32'(bus_a.ch_running[0]), 32'h1);
    idle(99);
    emit(16'h0020);
    check("t1_done", 32'(bus_a.ch_done[0]), 32'h1);
    readout(3'd0, 1'b0, 3'd0);
    check("t1_rd_cyc", 32'(bus_a.rd_data), 32'h064);

    emit(16'h0030);
    idle(12344);
    emit(16'h0031);
    check("t2_sat_b", 32'(bus_b.ch_sat), 32'h2);
    check("t2_sat_a", 32'(bus_a.ch_sat), 32'h0);

    emit(16'h0050);
    idle(49);
    emit(16'h0060);
    idle(5);
    emit(16'h0050);
    check("t3_acc_resume", 32'(bus_a.ch_running[2]), 32'h1);
    check("t3_oneshot_ignore", 32'(bus_a.ch_running[3]), 32'h0);
    idle(29);
    emit(16'h0060);
    check("t3_all_done", 32'(bus_a.all_done), 32'h1);

    for (int i = 0; i < 13; i++) begin
      readout(vecs[i].ch, vecs[i].dec, vecs[i].win);
      check($sformatf("vec%0d_rd_data", i), 32'(bus_a.rd_data), 32'(vecs[i].exp));
    end
    readout(3'd1, 1'b0, 3'd0);
    check("b_cyc_saturated", 32'(bus_b.rd_data), 32'h0FF);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_done", 32'(bus_a.ch_done), 32'h0);
    check("clear_sat_b", 32'(bus_b.ch_sat), 32'h0);
    check("clear_all_done", 32'(bus_a.all_done), 32'h0);
    readout(3'd1, 1'b0, 3'd0);
    check("clear_rd_data", 32'(bus_a.rd_data), 32'h0);

    start_pc[15:0] = 16'h0040;
    stop_pc[15:0]  = 16'h0040;
    emit(16'h0040);
    check("t5_running", 32'(bus_a.ch_running[0]), 32'h1);
    idle(9);
    emit(16'h0040);
    check("t5_done", 32'(bus_a.ch_done[0]), 32'h1);
    readout(3'd0, 1'b0, 3'd0);
    check("t5_rd_cyc", 32'(bus_a.rd_data), 32'h00A);

    accumulate[0] = 1'b1;
    emit(16'h0040);
    idle(3);
    pc = 16'h0040;
    pc_valid = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pc_valid = 1'b0;
    check("t6_reset_running", 32'(bus_a.ch_running), 32'h0);
    check("t6_reset_all_done", 32'(bus_a.all_done), 32'h0);
    readout(3'd0, 1'b0, 3'd0);
    check("t6_reset_rd_data", 32'(bus_a.rd_data), 32'h0);

    for (int n = 0; n < 4000; n++) begin
      if (n % 1000 == 0) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          int si, pi;
          si = $urandom_range(0, 4);
          pi = $urandom_range(0, 4);
          start_pc[ch*ADDR_W +: ADDR_W] = pool[si];
          stop_pc[ch*ADDR_W +: ADDR_W]  = pool[pi];
        end
        accumulate = 4'($urandom);
      end
      begin
        int pi;
        pi = $urandom_range(0, 4);
        pc = ($urandom_range(0, 7) == 0) ? 16'($urandom) : pool[pi];
      end
      pc_valid  = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 299) == 0);
      reset     = ($urandom_range(0, 799) == 0);
      rd_ch     = 3'($urandom_range(0, 7));
      rd_hund   = 1'($urandom_range(0, 1));
      rd_window = 3'($urandom_range(0, 2));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/multi_perf_counter.md
# multi_perf_counter

Parametrised multi-channel successor to the single-window performance counter. Each of NUM_CH channels watches the CPU program counter, counts CLK_50 cycles and hundredths of a second between a start PC and a stop PC, and can run one-shot or accumulate across repeated passes. A pipelined readout port formats any channel's count as hex nibbles or decimal hundredths for the 7-segment and VGA number displays.

## Interface
Parameters:
- NUM_CH, 4, number of independent channels (1..8)
- ADDR_W, 16, program-counter width
- CNT_W, 32, cycle-counter width per channel (multiple of 4)
- HUND_W, 14, hundredths-counter width per channel
- PRESCALE, 500_000, CLK_50 cycles per hundredth of a second

Ports:
- CLK_50  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- pc  in  ADDR_W  current CPU program counter
- pc_valid  in  1  pc is meaningful this cycle
- start_pc  in  NUM_CH*ADDR_W  per-channel start address, channel i at [i*ADDR_W +: ADDR_W]
- stop_pc  in  NUM_CH*ADDR_W  per-channel stop address, same packing
- accumulate  in  NUM_CH  per-channel mode: 0 one-shot, 1 accumulate
- clear  in  1  synchronous clear of all channels
- rd_ch  in  3  channel to read
- rd_hund  in  1  0 selects cycle count (hex), 1 selects hundredths (decimal)
- rd_window  in  3  nibble/digit window select
- rd_data  out  12  three nibbles/digits, [3:0] least significant
- ch_running  out  NUM_CH  channel in RUN
- ch_done  out  NUM_CH  channel in DONE
- ch_sat  out  NUM_CH  sticky: a counter of this channel saturated
- all_done  out  1  every channel in DONE

## Operation
- Per-channel FSM states: IDLE, RUN, DONE. start_hit = pc_valid && pc == start_pc[i]; stop_hit = pc_valid && pc == stop_pc[i].
- IDLE: start_hit -> RUN. cyc, presc and hund are already zero, and stay zero on entry.
- RUN: cyc += 1 every cycle, including the stop_hit cycle. stop_hit -> DONE. start_hit in RUN is ignored.
- DONE, accumulate[i]=0: holds values until clear/reset. start_hit is ignored.
- DONE, accumulate[i]=1: start_hit -> RUN with cyc/presc/hund retained. Counting resumes on the next cycle.
- Same-cycle start_hit and stop_hit in IDLE or DONE: start wins, stop is ignored. In RUN: stop wins.
- Prescaler: presc increments on each RUN cycle. When presc == PRESCALE-1 it wraps to 0 and hund += 1.
- Saturation:
  - cyc saturates at 2^CNT_W-1 and hund at 2^HUND_W-1. Each saturates independently.
  - Either saturating sets ch_sat[i], which holds until clear/reset.
  - A saturated hund also freezes presc.
- clear and reset: all channels -> IDLE; cyc, presc, hund, ch_sat zeroed. Both take priority over any pc match that cycle.
- Readout, rd_hund=0: rd_data = nibbles [3w+2 : 3w] of cyc, where w = rd_window. Nibbles at or above CNT_W/4 read 0.
- Readout, rd_hund=1: hund converted to decimal digits. rd_data = digits [3w+2 : 3w], digit 0 = units. Digits beyond the value's width read 0.
- rd_ch >= NUM_CH: rd_data = 0.

## Timing
- Reset values: all outputs 0. rd_data is 0 two cycles after reset is deasserted.
- FSM, counter and status outputs are registered; they reflect a pc match one cycle after the match cycle.
- Start at cycle t, stop at cycle t+k: final cyc = k.
- Readout is a 2-stage pipeline:
  - Stage 1 registers the selected channel's cyc/hund plus rd_hund/rd_window.
  - Stage 2 registers the formatted rd_data. Decimal conversion uses constant divide/modulo by powers of ten, or equivalent.
  - rd_data reflects rd_* inputs and counter values sampled 2 cycles earlier.
- all_done = AND of ch_done, registered alongside ch_done (no extra latency).
- No handshake. Inputs are sampled every cycle; pc_valid=0 suppresses both hits.

## Test plan
- Ch0 start=0x0010, stop=0x0020, one-shot. pc=0x10 at cycle 5, pc=0x20 at cycle 105 -> ch_done[0]=1 at cycle 106, cyc=100. Readout rd_ch=0, rd_hund=0, w=0 -> rd_data=0x064 two cycles later.
- PRESCALE=10 build, ch1 runs 12345 cycles -> hund=1234. Readout with rd_hund=1: w=0 gives 0x234, w=1 gives 0x001.
- Ch2 accumulate: two passes of 50 and 30 cycles -> cyc=80, ch_done[2]=1 after the second stop. One-shot ch3 on the same pattern -> cyc=50; its second start is ignored.
- CNT_W=8 build, RUN for 300 cycles -> cyc=255, ch_sat=1. clear -> cyc=0, ch_sat=0, state IDLE.
- start_pc == stop_pc == 0x40, pc=0x40 at cycles 10 and 20 -> RUN from cycle 11, DONE with cyc=10.
- reset asserted mid-RUN while pc matches stop -> reset wins: IDLE, cyc=0, all_done=0. rd_ch=7 with NUM_CH=4 -> rd_data=0.
